// File: rtl/alu_seq.sv
// =============================================================================
// alu_seq : sequential MIPS-decoding ALU with iterative mul/div and HI/LO
// Rev 1.0
// =============================================================================
`default_nettype none

module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_datain,
  input  logic [WIDTH-1:0] gr1,
  input  logic [WIDTH-1:0] gr2,
  output logic             o_valid,
  output logic [WIDTH-1:0] c,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             divz,
  output logic             illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_SLLV  = 6'h04;
  localparam logic [5:0] F_SRLV  = 6'h06;
  localparam logic [5:0] F_SRAV  = 6'h07;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2a;
  localparam logic [5:0] F_SLTU  = 6'h2b;

  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [SHW-1:0]   CNT_INIT = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ITER = 2'd1, S_FIX = 2'd2} state_t;

  state_t state_q, state_d;

  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opnd_q, opnd_d;
  logic             is_div_q, is_div_d, negres_q, negres_d, negrem_q, negrem_d;
  logic             mdovf_q, mdovf_d, mddivz_q, mddivz_d;
  logic [WIDTH-1:0] c_q, c_d, hi_q, hi_d, lo_q, lo_d;
  logic             valid_q, valid_d, zero_q, zero_d, neg_q, neg_d;
  logic             ovf_q, ovf_d, divz_q, divz_d, ill_q, ill_d;

  // Instruction fields and operand views
  logic [5:0]       w_op, w_funct;
  logic [5:0]       w_sh_ext;
  logic [63:0]      w_simm_ext;
  logic [WIDTH-1:0] w_simm, w_zimm;
  logic [SHW-1:0]   w_sh, w_shv;
  logic [WIDTH-1:0] w_add_rr, w_sub_rr, w_add_ri;
  logic             w_ovf_add, w_ovf_sub, w_ovf_addi;
  logic             w_accept;

  assign w_op       = i_datain[31:26];
  assign w_funct    = i_datain[5:0];
  assign w_sh_ext   = {1'b0, i_datain[10:6]};
  assign w_sh       = w_sh_ext[SHW-1:0];
  assign w_shv      = gr2[SHW-1:0];
  assign w_simm_ext = {{48{i_datain[15]}}, i_datain[15:0]};
  assign w_simm     = w_simm_ext[WIDTH-1:0];
  assign w_zimm     = WIDTH'(i_datain[15:0]);

  assign w_add_rr   = gr1 + gr2;
  assign w_sub_rr   = gr1 - gr2;
  assign w_add_ri   = gr1 + w_simm;
  assign w_ovf_add  = (gr1[WIDTH-1] == gr2[WIDTH-1])    && (w_add_rr[WIDTH-1] != gr1[WIDTH-1]);
  assign w_ovf_sub  = (gr1[WIDTH-1] != gr2[WIDTH-1])    && (w_sub_rr[WIDTH-1] != gr1[WIDTH-1]);
  assign w_ovf_addi = (gr1[WIDTH-1] == w_simm[WIDTH-1]) && (w_add_ri[WIDTH-1] != gr1[WIDTH-1]);

  logic w_unused;
  assign w_unused = ^{i_datain[25:16], w_sh_ext, w_simm_ext};

  assign o_ready  = (state_q == S_IDLE) && !rst;
  assign w_accept = i_valid && o_ready;

  // Single-cycle decode; mul/div ops only raise md_start here
  logic [WIDTH-1:0] sc_res;
  logic             sc_ovf, sc_ill, md_start, md_div, md_sgn;

  always_comb begin
    sc_res   = '0;
    sc_ovf   = 1'b0;
    sc_ill   = 1'b0;
    md_start = 1'b0;
    md_div   = 1'b0;
    md_sgn   = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        case (w_funct)
          F_SLL:   sc_res = gr1 << w_sh;
          F_SRL:   sc_res = gr1 >> w_sh;
          F_SRA:   sc_res = $signed(gr1) >>> w_sh;
          F_SLLV:  sc_res = gr1 << w_shv;
          F_SRLV:  sc_res = gr1 >> w_shv;
          F_SRAV:  sc_res = $signed(gr1) >>> w_shv;
          F_MFHI:  sc_res = hi_q;
          F_MFLO:  sc_res = lo_q;
          F_MULT:  begin md_start = 1'b1; md_sgn = 1'b1; end
          F_MULTU: md_start = 1'b1;
          F_DIV:   begin md_start = 1'b1; md_div = 1'b1; md_sgn = 1'b1; end
          F_DIVU:  begin md_start = 1'b1; md_div = 1'b1; end
          F_ADD:   begin sc_res = w_add_rr; sc_ovf = w_ovf_add; end
          F_ADDU:  sc_res = w_add_rr;
          F_SUB:   begin sc_res = w_sub_rr; sc_ovf = w_ovf_sub; end
          F_SUBU:  sc_res = w_sub_rr;
          F_AND:   sc_res = gr1 & gr2;
          F_OR:    sc_res = gr1 | gr2;
          F_XOR:   sc_res = gr1 ^ gr2;
          F_NOR:   sc_res = ~(gr1 | gr2);
          F_SLT:   sc_res = WIDTH'($signed(gr1) < $signed(gr2));
          F_SLTU:  sc_res = WIDTH'(gr1 < gr2);
          default: sc_ill = 1'b1;
        endcase
      end
      OP_BEQ, OP_BNE:        sc_res = w_sub_rr;
      OP_ADDI:               begin sc_res = w_add_ri; sc_ovf = w_ovf_addi; end
      OP_ADDIU, OP_LW, OP_SW: sc_res = w_add_ri;
      OP_SLTI:               sc_res = WIDTH'($signed(gr1) < $signed(w_simm));
      OP_SLTIU:              sc_res = WIDTH'(gr1 < w_simm);
      OP_ANDI:               sc_res = gr1 & w_zimm;
      OP_ORI:                sc_res = gr1 | w_zimm;
      OP_XORI:               sc_res = gr1 ^ w_zimm;
      default:               sc_ill = 1'b1;
    endcase
  end

  // Engine step: shift-add multiply and restoring divide share acc_hi/acc_lo
  logic [WIDTH-1:0]   w_a_abs, w_b_abs;
  logic [WIDTH:0]     w_mul_sum, w_div_rs, w_div_trial;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix, w_rem_fix;

  assign w_a_abs     = (md_sgn && gr1[WIDTH-1]) ? -gr1 : gr1;
  assign w_b_abs     = (md_sgn && gr2[WIDTH-1]) ? -gr2 : gr2;
  assign w_mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
  assign w_div_rs    = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign w_div_trial = w_div_rs - {1'b0, opnd_q};
  assign w_prod      = {acc_hi_q, acc_lo_q};
  assign w_prod_fix  = negres_q ? -w_prod : w_prod;
  assign w_quo_fix   = negres_q ? -acc_lo_q : acc_lo_q;
  assign w_rem_fix   = negrem_q ? -acc_hi_q : acc_hi_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    negres_d = negres_q;
    negrem_d = negrem_q;
    mdovf_d  = mdovf_q;
    mddivz_d = mddivz_q;
    c_d      = c_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    valid_d  = 1'b0;
    zero_d   = zero_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    divz_d   = divz_q;
    ill_d    = ill_q;
    case (state_q)
      S_IDLE: begin
        if (w_accept && md_start) begin
          state_d  = S_ITER;
          cnt_d    = CNT_INIT;
          is_div_d = md_div;
          acc_hi_d = '0;
          negrem_d = 1'b0;
          mdovf_d  = 1'b0;
          mddivz_d = 1'b0;
          if (md_div && (gr2 == '0)) begin
            // Dividing the raw dividend by zero leaves lo=all ones, hi=dividend
            acc_lo_d = gr1;
            opnd_d   = '0;
            negres_d = 1'b0;
            mddivz_d = 1'b1;
          end else begin
            acc_lo_d = md_div ? w_a_abs : w_b_abs;
            opnd_d   = md_div ? w_b_abs : w_a_abs;
            negres_d = md_sgn && (gr1[WIDTH-1] ^ gr2[WIDTH-1]);
            negrem_d = md_div && md_sgn && gr1[WIDTH-1];
            mdovf_d  = md_div && md_sgn && (gr1 == MIN_VAL) && (gr2 == '1);
          end
        end else if (w_accept) begin
          valid_d = 1'b1;
          c_d     = sc_res;
          zero_d  = !sc_ill && (sc_res == '0);
          neg_d   = !sc_ill && sc_res[WIDTH-1];
          ovf_d   = sc_ovf;
          divz_d  = 1'b0;
          ill_d   = sc_ill;
        end
      end
      S_ITER: begin
        if (is_div_q) begin
          acc_hi_d = w_div_trial[WIDTH] ? w_div_rs[WIDTH-1:0] : w_div_trial[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], ~w_div_trial[WIDTH]};
        end else begin
          acc_hi_d = w_mul_sum[WIDTH:1];
          acc_lo_d = {w_mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_FIX: begin
        state_d = S_IDLE;
        valid_d = 1'b1;
        ovf_d   = mdovf_q;
        divz_d  = mddivz_q;
        ill_d   = 1'b0;
        if (is_div_q) begin
          hi_d   = w_rem_fix;
          lo_d   = w_quo_fix;
          c_d    = w_quo_fix;
          zero_d = (w_quo_fix == '0);
          neg_d  = w_quo_fix[WIDTH-1];
        end else begin
          hi_d   = w_prod_fix[2*WIDTH-1:WIDTH];
          lo_d   = w_prod_fix[WIDTH-1:0];
          c_d    = w_prod_fix[WIDTH-1:0];
          zero_d = (w_prod_fix == '0);
          neg_d  = w_prod_fix[2*WIDTH-1];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      negres_q <= 1'b0;
      negrem_q <= 1'b0;
      mdovf_q  <= 1'b0;
      mddivz_q <= 1'b0;
      c_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      valid_q  <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      divz_q   <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      negres_q <= negres_d;
      negrem_q <= negrem_d;
      mdovf_q  <= mdovf_d;
      mddivz_q <= mddivz_d;
      c_q      <= c_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      valid_q  <= valid_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      divz_q   <= divz_d;
      ill_q    <= ill_d;
    end
  end

  assign o_valid  = valid_q;
  assign c        = c_q;
  assign zero     = zero_q;
  assign negative = neg_q;
  assign overflow = ovf_q;
  assign divz     = divz_q;
  assign illegal  = ill_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// =============================================================================
// tb_alu_seq : scoreboard bench for alu_seq (WIDTH=32 and WIDTH=16 instances)
// Rev 1.0
// =============================================================================
`default_nettype none

module tb_alu_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        v32 = 1'b0, r32, ov32, z32, n32, o32, dz32, il32;
  logic [31:0] ins32 = '0, a32 = '0, b32 = '0, c32, hi32, lo32;
  logic        v16 = 1'b0, r16, ov16, z16, n16, o16, dz16, il16;
  logic [31:0] ins16 = '0;
  logic [15:0] a16 = '0, b16 = '0, c16, hi16, lo16;

  alu_seq #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .i_valid(v32), .o_ready(r32), .i_datain(ins32),
    .gr1(a32), .gr2(b32), .o_valid(ov32), .c(c32), .zero(z32), .negative(n32),
    .overflow(o32), .divz(dz32), .illegal(il32), .hi(hi32), .lo(lo32));

  alu_seq #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .i_valid(v16), .o_ready(r16), .i_datain(ins16),
    .gr1(a16), .gr2(b16), .o_valid(ov16), .c(c16), .zero(z16), .negative(n16),
    .overflow(o16), .divz(dz16), .illegal(il16), .hi(hi16), .lo(lo16));

  typedef struct {
    string       nm;
    logic [31:0] c, hi, lo;
    logic [4:0]  fl;      // {zero, negative, overflow, divz, illegal}
    bit          chk_hl;
    int          due;
  } exp_t;

  exp_t q32[$];
  exp_t q16[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rtype(input logic [5:0] f, input logic [4:0] sh);
    return {6'h00, 5'd1, 5'd2, 5'd3, sh, f};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] imm);
    return {op, 5'd1, 5'd2, imm};
  endfunction

  task automatic compare(input exp_t e, input logic [31:0] c, hi, lo, input logic [4:0] fl);
    bit bad;
    checks++;
    bad = (c !== e.c) || (fl !== e.fl) || (cyc != e.due) ||
          (e.chk_hl && ((hi !== e.hi) || (lo !== e.lo)));
    if (bad) begin
      errors++;
      $display("FAIL %s: got c=%h hi=%h lo=%h flags=%b cycle=%0d, want c=%h hi=%h lo=%h flags=%b cycle=%0d",
               e.nm, c, hi, lo, fl, cyc, e.c, e.hi, e.lo, e.fl, e.due);
    end
  endtask

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // Monitors: every o_valid pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (ov32 === 1'b1) begin
      if (q32.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid32: got c=%h at cycle %0d, want no o_valid", c32, cyc);
      end else compare(q32.pop_front(), c32, hi32, lo32, {z32, n32, o32, dz32, il32});
    end
  end

  always @(negedge clk) begin
    if (ov16 === 1'b1) begin
      if (q16.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid16: got c=%h at cycle %0d, want no o_valid", c16, cyc);
      end else compare(q16.pop_front(), {16'h0, c16}, {16'h0, hi16}, {16'h0, lo16},
                       {z16, n16, o16, dz16, il16});
    end
  end

  // Called just after a negedge; waits (bounded) for o_ready, then drives one request
  task automatic issue(input bit w16, input string nm, input logic [31:0] ins, a, b,
                       input logic [31:0] ec, ehi, elo, input logic [4:0] efl,
                       input bit chk, input int lat);
    int   n;
    exp_t e;
    n = 0;
    while (!(w16 ? r16 : r32) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL %s_ready_timeout: got o_ready=0 for %0d cycles, want 1", nm, n);
      return;
    end
    e.nm = nm; e.c = ec; e.hi = ehi; e.lo = elo; e.fl = efl; e.chk_hl = chk;
    e.due = cyc + 1 + lat;
    if (w16) begin
      ins16 = ins; a16 = a[15:0]; b16 = b[15:0]; v16 = 1'b1;
      q16.push_back(e);
    end else begin
      ins32 = ins; a32 = a; b32 = b; v32 = 1'b1;
      q32.push_back(e);
    end
    @(negedge clk);
    v16 = 1'b0;
    v32 = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_state32", {r32, ov32, z32, n32, o32, dz32, il32, c32, hi32, lo32},
          {1'b1, 6'b0, 96'h0});
    check("reset_state16", {r16, ov16, z16, n16, o16, dz16, il16, c16, hi16, lo16},
          {1'b1, 6'b0, 48'h0});
    @(negedge clk);

    // Single-cycle ops (latency 0 extra edges: result after the accept edge)
    issue(0, "add_ovf",  rtype(6'h20, 0), 32'h7FFFFFFF, 32'h8, 32'h80000007, 0, 0, 5'b01100, 1, 0);
    issue(0, "addu",     rtype(6'h21, 0), 32'h7FFFFFFF, 32'h8, 32'h80000007, 0, 0, 5'b01000, 1, 0);
    issue(0, "sub_ovf",  rtype(6'h22, 0), 32'h80000000, 32'h1, 32'h7FFFFFFF, 0, 0, 5'b00100, 0, 0);
    issue(0, "beq_eq",   itype(6'h04, 16'h0003), 32'h9, 32'h9, 32'h0, 0, 0, 5'b10000, 0, 0);
    issue(0, "sra",      rtype(6'h03, 5'd21), 32'h80000000, 32'h0, 32'hFFFFFC00, 0, 0, 5'b01000, 0, 0);
    issue(0, "sllv",     rtype(6'h04, 0), 32'h3, 32'h1, 32'h6, 0, 0, 5'b00000, 0, 0);
    issue(0, "sltiu",    itype(6'h0b, 16'h8000), 32'h7, 32'h0, 32'h1, 0, 0, 5'b00000, 0, 0);
    issue(0, "slt",      rtype(6'h2a, 0), 32'hFFFFFFFF, 32'h1, 32'h1, 0, 0, 5'b00000, 0, 0);
    issue(0, "andi",     itype(6'h0c, 16'h8001), 32'hFFFFFFFF, 32'h0, 32'h8001, 0, 0, 5'b00000, 0, 0);
    issue(0, "nor",      rtype(6'h27, 0), 32'h0, 32'h0, 32'hFFFFFFFF, 0, 0, 5'b01000, 0, 0);
    issue(0, "add_ovf2", rtype(6'h20, 0), 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 0, 5'b01100, 0, 0);
    issue(0, "illegal",  rtype(6'h3f, 0), 32'h5, 32'h6, 32'h0, 0, 0, 5'b00001, 1, 0);
    issue(0, "addi_neg", itype(6'h08, 16'hFFFF), 32'h1, 32'h0, 32'h0, 0, 0, 5'b10000, 0, 0);

    // Mul/div (WIDTH+1 extra edges), with MFHI/MFLO issued in the o_valid cycle
    issue(0, "mult",   rtype(6'h18, 0), 32'h00FFFFFF, 32'h00FFFFFF, 32'hFE000001, 32'h0000FFFF, 32'hFE000001, 5'b00000, 1, 33);
    issue(0, "mfhi",   rtype(6'h10, 0), 32'h0, 32'h0, 32'h0000FFFF, 0, 0, 5'b00000, 0, 0);
    issue(0, "mflo",   rtype(6'h12, 0), 32'h0, 32'h0, 32'hFE000001, 0, 0, 5'b01000, 0, 0);
    issue(0, "div",    rtype(6'h1a, 0), 32'h8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h2, 32'hFFFFFFFE, 5'b01000, 1, 33);
    issue(0, "div_ov", rtype(6'h1a, 0), 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 32'h80000000, 5'b01100, 1, 33);
    issue(0, "divu_z", rtype(6'h1b, 0), 32'h5, 32'h0, 32'hFFFFFFFF, 32'h5, 32'hFFFFFFFF, 5'b01010, 1, 33);
    issue(0, "mult_n", rtype(6'h18, 0), 32'hFFFFFFFD, 32'h5, 32'hFFFFFFF1, 32'hFFFFFFFF, 32'hFFFFFFF1, 5'b01000, 1, 33);
    issue(0, "div_nn", rtype(6'h1a, 0), 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD, 5'b01000, 1, 33);

    // Request during ITER is dropped and later operand changes are ignored
    issue(0, "multu_hold", rtype(6'h19, 0), 32'h80000001, 32'h1, 32'h80000001, 32'h0, 32'h80000001, 5'b00000, 1, 33);
    repeat (4) @(negedge clk);
    check("ready_low_iter", {63'h0, r32}, 64'h0);
    ins32 = rtype(6'h20, 0); a32 = 32'h1; b32 = 32'h1; v32 = 1'b1;
    @(negedge clk);
    v32 = 1'b0; a32 = 32'hDEAD0000;
    issue(0, "mflo_hold", rtype(6'h12, 0), 32'h0, 32'h0, 32'h80000001, 0, 0, 5'b01000, 0, 0);

    // Reset in the middle of a MULT: no result, HI/LO cleared, ready on release
    ins32 = rtype(6'h18, 0); a32 = 32'h1234; b32 = 32'h5678; v32 = 1'b1;
    @(negedge clk);
    v32 = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("ready_in_reset", {63'h0, r32}, 64'h0);
    check("hilo_after_reset", {hi32, lo32}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_release", {63'h0, r32}, 64'h1);
    repeat (40) @(negedge clk);
    issue(0, "mfhi_reset", rtype(6'h10, 0), 32'h0, 32'h0, 32'h0, 0, 0, 5'b10000, 0, 0);

    // WIDTH=16 instance
    issue(1, "mult16", rtype(6'h18, 0), 32'h7FFF, 32'h7FFF, 32'h0001, 32'h3FFF, 32'h0001, 5'b00000, 1, 17);
    issue(1, "addi16", itype(6'h08, 16'h0001), 32'h7FFF, 32'h0, 32'h8000, 0, 0, 5'b01100, 0, 0);
    issue(1, "sll16",  rtype(6'h00, 5'd17), 32'h1, 32'h0, 32'h2, 0, 0, 5'b00000, 0, 0);

    repeat (50) @(negedge clk);
    check("q32_drained", 64'(q32.size()), 64'h0);
    check("q16_drained", 64'(q16.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_seq.md
# alu_seq

Sequential, width-parametrised successor to the single-cycle MIPS ALU. It decodes a 32-bit MIPS instruction word and executes the same operation set on WIDTH-bit operands. Logical, arithmetic, compare and shift ops complete in one cycle. MULT/MULTU/DIV/DIVU run on an iterative shift-add / restoring-divide engine into architectural HI/LO registers, which MFHI/MFLO read back. It sits between operand fetch and writeback, with a valid/ready handshake on the input side.

## Interface
- WIDTH, 32, operand/result width; legal values 8..64.
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override).
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  request strobe.
- o_ready  out  1  block can accept a request this cycle.
- i_datain  in  32  MIPS instruction word: opcode [31:26], shamt [10:6], funct [5:0], imm [15:0].
- gr1  in  WIDTH  rs operand; this is the operand that gets shifted.
- gr2  in  WIDTH  rt operand; it also supplies the variable shift amount in gr2[SHW-1:0].
- o_valid  out  1  one-cycle result pulse.
- c  out  WIDTH  result.
- zero, negative, overflow  out  1 each  status flags.
- divz  out  1  divide-by-zero flag.
- illegal  out  1  unsupported instruction.
- hi, lo  out  WIDTH each  HI/LO registers.

## Operation
- Acceptance: a request is accepted when i_valid && o_ready at a rising edge. Instruction and operands are latched at that edge; later input changes have no effect. i_valid while o_ready=0 is ignored, not queued.
- FSM: IDLE -> ITER -> FIX -> IDLE.
  - IDLE: o_ready=1.
  - Single-cycle op accepted: registers its result and stays in IDLE.
  - Mul/div op accepted: moves to ITER, which runs exactly WIDTH cycles, then to FIX for one cycle (sign correction, HI/LO write), then back to IDLE.
- Immediate extension:
  - Sign-extend to WIDTH for ADDI, ADDIU, SLTI, SLTIU, LW, SW, BEQ, BNE.
  - Zero-extend for ANDI, ORI, XORI.
- Arithmetic ops:
  - ADD/ADDI/SUB: overflow = signed overflow. c is still the wrapped sum.
  - ADDU/ADDIU/SUBU/LW/SW: overflow=0.
  - BEQ/BNE: c = gr1 - gr2, and zero reports equality.
- Compare ops: SLT/SLTI are signed and SLTU/SLTIU unsigned. c is 0 or 1.
- Logic ops: AND, ANDI, OR, ORI, XOR, XORI, NOR (bitwise).
- Shift ops:
  - SLL/SRL/SRA shift gr1 by shamt, using the low SHW bits when WIDTH<32.
  - SLLV/SRLV/SRAV shift gr1 by gr2[SHW-1:0].
- MULT/MULTU: {hi,lo} = 2*WIDTH-bit product (signed or unsigned). c=lo. zero and negative are evaluated on the full {hi,lo}.
- DIV/DIVU:
  - Quotient goes to lo, remainder to hi, truncating toward zero; the remainder takes the dividend's sign. c=lo.
  - Flags zero and negative come from lo.
  - DIV of MIN / -1: lo=MIN, hi=0, overflow=1.
- Divide by zero: divisor 0 gives lo = all ones, hi = dividend, divz=1, no trap.
- MFHI/MFLO (funct 010000/010010): c = hi/lo, single-cycle.
- Flags for single-cycle ops: zero=(c==0) and negative=c[WIDTH-1].
- Flag clearing: overflow, divz and illegal are cleared on every op that does not set them.
- Unsupported opcode/funct: c=0, illegal=1, all other flags 0; HI/LO unchanged.
- Register hold: HI/LO change only at FIX. c and all flags hold their last value until the next o_valid.

## Timing
- Reset (async assert):
  - state=IDLE.
  - c, hi, lo, and all flags = 0.
  - o_valid=0.
  - o_ready=0 while rst is high; o_ready=1 in the first cycle after release.
- Single-cycle ops: accept at edge k, then o_valid=1 and results valid in cycle k+1 (after edge k). o_ready stays 1, so back-to-back issue is allowed every cycle.
- Mul/div ops: accept at edge k, then o_ready=0 from k until FIX completes. o_valid pulses after edge k+WIDTH+1, so latency is WIDTH+1 cycles (33 for WIDTH=32), with hi/lo updated at the same edge. o_ready=1 in that same cycle, so a new request may be accepted in the o_valid cycle.
- MFHI/MFLO issued in the o_valid cycle of a MULT/DIV returns the new HI/LO.
- Reset mid-ITER/FIX: abort immediately; HI/LO are cleared and no o_valid is produced.
- No output back-pressure: o_valid is a pulse, and consumers must sample it.

## Test plan
- ADD 0x7FFFFFFF + 0x00000008 (WIDTH=32) -> o_valid one cycle after accept, c=0x80000007, overflow=1, negative=1. ADDU with the same operands gives the same c with overflow=0.
- MULT 0x00FFFFFF * 0x00FFFFFF -> o_ready low for 33 cycles. o_valid 33 cycles after accept with hi=0x0000FFFF, lo=0xFE000001, zero=0. A following MFHI gives c=0x0000FFFF.
- DIV 8 / 0xFFFFFFFD -> lo=0xFFFFFFFE, hi=2, negative=1. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, overflow=1. DIVU 5 / 0 -> lo=0xFFFFFFFF, hi=5, divz=1.
- Issue MULTU 0x80000001*1, pulse i_valid (ADD 1+1) during ITER, and change gr1 -> the ADD is not accepted and the MULTU result is lo=0x80000001, hi=0. Then issue a new MULT and assert rst at cycle 10 -> no o_valid, hi=lo=0, o_ready=1 after release.
- Shifts: SRA 0x80000000 by shamt 21 -> c=0xFFFFFC00. SLLV gr1=3, gr2=1 -> c=6. SLTIU 7 vs imm 0x8000 -> c=1. Unsupported funct 111111 -> illegal=1, c=0.
- WIDTH=16 build: MULT 0x7FFF*0x7FFF -> hi=0x3FFF, lo=0x0001, latency 17. ADDI 0x7FFF + 1 -> c=0x8000, overflow=1. SLL 1 by shamt 17 -> uses shamt[3:0]=1, c=2.
